product_accumulator: RTL and testbench

// Downstream consumer of the 8x8 array multiplier. Collects a programmed

---
 rtl/product_accumulator.sv | 115 +++++++++++
 tb/tb_product_accumulator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Product accumulator: gathers a programmed number of unsigned products over a
// valid/ready handshake. It sums them into a saturating accumulator and
// presents the result on a second valid/ready handshake.
module product_accumulator #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  sum,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              ovf,
  output logic              busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W:0]   add_full;
  logic [ACC_W-1:0] add_sat;
  logic             add_ovf;

  // One extra bit catches the carry out; a carry means clamp to all ones.
  always_comb begin
    add_full = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    add_ovf  = add_full[ACC_W];
    add_sat  = add_ovf ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
  end

  // Next-state logic for the run FSM and datapath registers.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          cnt_d = len;
          if (len != '0) begin
            state_d = StAccum;
          end else begin
            // Empty run completes immediately with a zero result.
            sum_d   = '0;
            state_d = StDone;
          end
        end
      end
      StAccum: begin
        if (prod_valid) begin
          acc_d = add_sat;
          cnt_d = cnt_q - 1'b1;
          ovf_d = ovf_q | add_ovf;
          if (cnt_q == CNT_W'(1)) begin
            sum_d   = add_sat;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // start is deliberately ignored here, even alongside sum_ready.
        if (sum_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs decoded straight from the state register.
  always_comb begin
    prod_ready = (state_q == StAccum);
    sum_valid  = (state_q == StDone);
    busy       = (state_q != StIdle);
    sum        = sum_q;
    ovf        = ovf_q;
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a default 24-bit instance and a 17-bit
// instance share stimulus. Expected sums come from a saturating model and are
// queued at start and popped when sum_valid appears.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic [15:0] prod;
  logic        prod_valid;
  logic        sum_ready;

  logic        prod_ready, sum_valid, ovf, busy;
  logic [23:0] sum;
  logic        prod_ready17, sum_valid17, ovf17, busy17;
  logic [16:0] sum17;

  product_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .sum(sum),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .ovf(ovf), .busy(busy)
  );

  product_accumulator #(.PROD_W(16), .ACC_W(17), .CNT_W(8)) dut17 (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready17), .sum(sum17),
    .sum_valid(sum_valid17), .sum_ready(sum_ready), .ovf(ovf17), .busy(busy17)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned s24;
    bit              o24;
    longint unsigned s17;
    bit              o17;
  } exp_t;

  exp_t        sb[$];
  int unsigned pv[8];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Saturating reference model for one run at a given accumulator width.
  function automatic exp_t model(input int n);
    exp_t e;
    longint unsigned m24 = (64'd1 << 24) - 1;
    longint unsigned m17 = (64'd1 << 17) - 1;
    e.s24 = 0; e.o24 = 0; e.s17 = 0; e.o17 = 0;
    for (int i = 0; i < n; i++) begin
      e.s24 += pv[i];
      e.s17 += pv[i];
      if (e.s24 > m24) begin e.s24 = m24; e.o24 = 1; end
      if (e.s17 > m17) begin e.s17 = m17; e.o17 = 1; end
    end
    return e;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " sum_valid"}, {31'd0, sum_valid}, 0);
    check_eq({tag, " prod_ready"}, {31'd0, prod_ready}, 0);
    check_eq({tag, " busy"}, {31'd0, busy}, 0);
  endtask

  // Runs one transaction of n products from pv[]. gaps toggles prod_valid,
  // hold keeps sum_ready low that many cycles, start_on_ack raises start
  // together with sum_ready.
  task automatic run(input string tag, input int n, input bit gaps, input int hold,
                     input bit start_on_ack);
    int   idx = 0;
    int   cyc = 0;
    exp_t e;
    sb.push_back(model(n));
    @(negedge clk);
    start = 1'b1;
    len   = 8'(n);
    while (idx < n) begin
      @(negedge clk);
      start = 1'b0;
      len   = 8'hff;  // changes outside the start cycle must be ignored
      check_eq({tag, " prod_ready"}, {31'd0, prod_ready}, 1);
      check_eq({tag, " prod_ready17"}, {31'd0, prod_ready17}, 1);
      if (gaps && cyc[0]) begin
        prod_valid = 1'b0;
        prod       = 16'hffff;
      end else begin
        prod_valid = 1'b1;
        prod       = 16'(pv[idx]);
        idx++;
      end
      cyc++;
    end
    @(negedge clk);
    start      = 1'b0;
    prod_valid = 1'b0;
    check_eq({tag, " sum_valid latency"}, {31'd0, sum_valid}, 1);
    check_eq({tag, " sum_valid17"}, {31'd0, sum_valid17}, 1);
    check_eq({tag, " prod_ready done"}, {31'd0, prod_ready}, 0);
    check_eq({tag, " busy done"}, {31'd0, busy}, 1);
    if (sb.size() == 0) begin
      check_eq({tag, " scoreboard empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check_eq({tag, " sum"}, {8'd0, sum}, 32'(e.s24));
      check_eq({tag, " ovf"}, {31'd0, ovf}, {31'd0, e.o24});
      check_eq({tag, " sum17"}, {15'd0, sum17}, 32'(e.s17));
      check_eq({tag, " ovf17"}, {31'd0, ovf17}, {31'd0, e.o17});
      // Offer junk products while waiting; none may be absorbed.
      for (int h = 0; h < hold; h++) begin
        prod_valid = 1'b1;
        prod       = 16'd1234;
        @(negedge clk);
        check_eq({tag, " hold sum"}, {8'd0, sum}, 32'(e.s24));
        check_eq({tag, " hold sum_valid"}, {31'd0, sum_valid}, 1);
      end
      prod_valid = 1'b0;
      sum_ready  = 1'b1;
      if (start_on_ack) begin
        start = 1'b1;
        len   = 8'd3;
      end
      @(negedge clk);
      sum_ready = 1'b0;
      start     = 1'b0;
      check_idle_outputs({tag, " after ack"});
      check_eq({tag, " sum retained"}, {8'd0, sum}, 32'(e.s24));
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    len        = 8'd0;
    prod       = 16'd0;
    prod_valid = 1'b0;
    sum_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check_eq("reset sum", {8'd0, sum}, 0);
    check_eq("reset ovf", {31'd0, ovf}, 0);
    rst = 1'b0;

    pv[0] = 60; pv[1] = 75; pv[2] = 200;
    run("t1", 3, 1'b0, 0, 1'b0);

    pv[0] = 61009; pv[1] = 61009; pv[2] = 61009;
    run("t2 sat", 3, 1'b0, 0, 1'b0);
    pv[0] = 5;
    run("t2 clear", 1, 1'b0, 0, 1'b0);

    pv[0] = 510; pv[1] = 200; pv[2] = 60; pv[3] = 75;
    run("t3", 4, 1'b1, 5, 1'b0);

    run("t4 len0", 0, 1'b0, 0, 1'b0);

    pv[0] = 60;
    run("t6", 1, 1'b0, 0, 1'b1);
    @(negedge clk);
    check_eq("t6 busy stays low", {31'd0, busy}, 0);
    check_eq("t6 sum still 60", {8'd0, sum}, 60);

    // Abort a run after two transfers with a reset pulse between edges.
    @(negedge clk);
    start = 1'b1;
    len   = 8'd4;
    @(negedge clk);
    start      = 1'b0;
    prod_valid = 1'b1;
    prod       = 16'd1000;
    @(negedge clk);
    prod = 16'd2000;
    @(negedge clk);
    prod_valid = 1'b0;
    check_eq("t5 busy before rst", {31'd0, busy}, 1);
    #1 rst = 1'b1;
    #1;
    check_idle_outputs("t5 async rst");
    check_eq("t5 rst sum", {8'd0, sum}, 0);
    check_eq("t5 rst ovf", {31'd0, ovf}, 0);
    rst = 1'b0;
    pv[0] = 510; pv[1] = 200;
    run("t5 rerun", 2, 1'b0, 0, 1'b0);

    check_eq("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
